piso_bit_source: RTL

Parallel-in/serial-out bit source that feeds the serial input of the sequence-detector stage. It accepts a NUM_BITS-wide word through a valid/ready handshake and emits it one bit at a time on `serial_out`, each bit held for CLKS_PER_BIT clocks. It supports gap-free back-to-back words, so the downstream detector sees a continuous bit stream.

---
 rtl/piso_bit_source.sv | 98 +++++++++
 1 files changed

// File: rtl/piso_bit_source.sv
// Parallel-in/serial-out bit source with valid/ready load and gap-free back-to-back words.
// Each bit is held for CLKS_PER_BIT clocks.
// Optional build macro PISO_LSB_FIRST_EN: send LSB first (the register shifts right).
// Default build: MSB first (the register shifts left).
module piso_bit_source #(
    parameter int unsigned NUM_BITS     = 8,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_en,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                ready,
    output logic                serial_out,
    output logic                bit_strobe,
    output logic                busy,
    output logic                done
);

    localparam int unsigned PerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [PerW-1:0] PerMax = PerW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] BitMax = BitW'(NUM_BITS - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e              state_q, state_d;
    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [PerW-1:0]     per_q, per_d;
    logic [BitW-1:0]     bit_q, bit_d;

    logic per_end;
    logic last;
    logic accept;

    // Outputs decoded from registered state only, never from load_en.
    always_comb begin
        per_end    = (state_q == StShift) && (per_q == PerMax);
        last       = per_end && (bit_q == BitMax);
        ready      = (state_q == StIdle) || last;
        done       = last;
        busy       = (state_q == StShift);
        bit_strobe = busy && (per_q == '0);
`ifdef PISO_LSB_FIRST_EN
        serial_out = busy && shift_q[0];
`else
        serial_out = busy && shift_q[NUM_BITS-1];
`endif
        accept     = load_en && ready;
    end

    // Next-state: a load on the last clock of a word reloads with no idle gap.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        per_d   = per_q;
        bit_d   = bit_q;
        if (accept) begin
            state_d = StShift;
            shift_d = parallel_in;
            per_d   = '0;
            bit_d   = '0;
        end else if (state_q == StShift) begin
            if (per_end) begin
                per_d = '0;
                if (last) begin
                    state_d = StIdle;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_q + 1'b1;
`ifdef PISO_LSB_FIRST_EN
                    shift_d = {1'b0, shift_q[NUM_BITS-1:1]};
`else
                    shift_d = {shift_q[NUM_BITS-2:0], 1'b0};
`endif
                end
            end else begin
                per_d = per_q + 1'b1;
            end
        end
    end

    // State registers; synchronous reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            per_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            per_q   <= per_d;
            bit_q   <= bit_d;
        end
    end

endmodule
